// File: rtl/type_pkg.sv
// Shared write/read-path types: host burst sizes and the pool byte-column geometry.
package type_pkg;

   typedef enum logic [1:0] {
      ONE_BYTE    = 2'd0,
      TWO_BYTES   = 2'd1,
      FOUR_BYTES  = 2'd2,
      EIGHT_BYTES = 2'd3
   } burst_size_t;

   localparam int unsigned BYTE_COLS = 8;

   function automatic logic [3:0] burst_bytes(input burst_size_t size);
      case (size)
         ONE_BYTE:   return 4'd1;
         TWO_BYTES:  return 4'd2;
         FOUR_BYTES: return 4'd4;
         default:    return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/wdata_fifo.sv
// Pool write FIFO of {word, data, strb} entries; the youngest entry can absorb a
// same-word beat in place instead of taking a new slot.
module wdata_fifo
   import type_pkg::*;
#(
   parameter int unsigned WORD_W    = 5,
   parameter int unsigned DATA_SIZE = 64,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                         clk,
   input  logic                         n_rst,
   input  logic                         in_valid,
   input  logic [WORD_W-1:0]            in_word,
   input  logic [DATA_SIZE-1:0]         in_data,
   input  logic [BYTE_COLS-1:0]         in_strb,
   output logic                         in_accept,
   input  logic                         pop,
   output logic [WORD_W-1:0]            head_word,
   output logic [DATA_SIZE-1:0]         head_data,
   output logic [BYTE_COLS-1:0]         head_strb,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WORD_W-1:0]    mem_word [DEPTH];
   logic [DATA_SIZE-1:0] mem_data [DEPTH];
   logic [BYTE_COLS-1:0] mem_strb [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] tail;
   logic             do_pop;
   logic             tail_busy;
   logic             merge;
   logic             push;

   assign tail      = wr_ptr - PTR_W'(1);
   assign do_pop    = pop && (count != '0);
   // With one entry the tail is the head; never merge into an entry leaving this cycle.
   assign tail_busy = do_pop && (count == CNT_W'(1));
   assign merge     = in_valid && (count != '0) && (mem_word[tail] == in_word) && !tail_busy;
   assign push      = in_valid && !merge && ((count < CNT_W'(DEPTH)) || do_pop);
   assign in_accept = merge || push;

   assign head_word = mem_word[rd_ptr];
   assign head_data = mem_data[rd_ptr];
   assign head_strb = mem_strb[rd_ptr];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_word[i] <= '0;
            mem_data[i] <= '0;
            mem_strb[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_word[wr_ptr] <= in_word;
            mem_data[wr_ptr] <= in_data;
            mem_strb[wr_ptr] <= in_strb;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (merge) begin
            for (int unsigned i = 0; i < BYTE_COLS; i++) begin
               if (in_strb[i]) mem_data[tail][8*i +: 8] <= in_data[8*i +: 8];
            end
            mem_strb[tail] <= mem_strb[tail] | in_strb;
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !do_pop)      count <= count + CNT_W'(1);
         else if (!push && do_pop) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/write_data_aligner.sv
// Rotates LSB-justified host write beats into their pool byte columns, builds strobes,
// and hands them through a coalescing FIFO to the write pool.
module write_data_aligner
   import type_pkg::*;
#(
   parameter int unsigned ADDR_SIZE = 8,
   parameter int unsigned DATA_SIZE = 64,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     wvalid,
   output logic                     wready,
   input  logic [ADDR_SIZE-1:0]     waddr,
   input  burst_size_t              wburst_size,
   input  logic [DATA_SIZE-1:0]     wdata,
   output logic                     pool_wen,
   input  logic                     pool_wready,
   output logic [ADDR_SIZE-1:0]     pool_waddr,
   output logic [DATA_SIZE-1:0]     pool_wdata,
   output logic [BYTE_COLS-1:0]     pool_wstrb,
   output logic                     misalign_err,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned WORD_W = ADDR_SIZE - 3;

   logic [3:0]             nbytes;
   logic [2:0]             col;
   logic [3:0]             end_col;
   logic                   misaligned;
   logic [BYTE_COLS-1:0]   byte_mask;
   logic [DATA_SIZE-1:0]   masked;
   logic [2*DATA_SIZE-1:0] data_dbl;
   logic [2*BYTE_COLS-1:0] strb_dbl;
   logic                   accept;

   logic                   align_valid;
   logic [WORD_W-1:0]      align_word;
   logic [DATA_SIZE-1:0]   align_data;
   logic [BYTE_COLS-1:0]   align_strb;
   logic                   align_adv;
   logic [WORD_W-1:0]      head_word;

   assign nbytes     = burst_bytes(wburst_size);
   assign col        = waddr[2:0];
   assign end_col    = {1'b0, col} + nbytes;
   assign misaligned = end_col > 4'd8;

   always_comb begin
      byte_mask = '0;
      masked    = '0;
      for (int unsigned i = 0; i < BYTE_COLS; i++) begin
         if (i < 32'(nbytes)) begin
            byte_mask[i]      = 1'b1;
            masked[8*i +: 8]  = wdata[8*i +: 8];
         end
      end
   end

   // Upper half of a doubled vector shifted left is a left rotation.
   assign data_dbl = {masked, masked} << {col, 3'b000};
   assign strb_dbl = {byte_mask, byte_mask} << col;

   assign wready = !align_valid || align_adv;
   assign accept = wvalid && wready;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         align_valid  <= 1'b0;
         align_word   <= '0;
         align_data   <= '0;
         align_strb   <= '0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= accept && misaligned;
         if (accept && !misaligned) begin
            align_valid <= 1'b1;
            align_word  <= waddr[ADDR_SIZE-1:3];
            align_data  <= data_dbl[2*DATA_SIZE-1 -: DATA_SIZE];
            align_strb  <= strb_dbl[2*BYTE_COLS-1 -: BYTE_COLS];
         end else if (align_adv) begin
            align_valid <= 1'b0;
         end
      end
   end

   assign pool_wen   = (fifo_count != '0);
   assign pool_waddr = {head_word, 3'b000};

   wdata_fifo #(
      .WORD_W    (WORD_W),
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .n_rst     (n_rst),
      .in_valid  (align_valid),
      .in_word   (align_word),
      .in_data   (align_data),
      .in_strb   (align_strb),
      .in_accept (align_adv),
      .pop       (pool_wen && pool_wready),
      .head_word (head_word),
      .head_data (pool_wdata),
      .head_strb (pool_wstrb),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_write_data_aligner.sv
// Directed bench for write_data_aligner: expected pool writes are queued at stimulus
// time and a monitor compares each pool handshake against the queue head.
module tb_write_data_aligner;
   import type_pkg::*;

   localparam int unsigned ADDR_SIZE = 8;
   localparam int unsigned DATA_SIZE = 64;
   localparam int unsigned DEPTH     = 4;

   logic                 clk = 1'b0;
   logic                 n_rst;
   logic                 wvalid;
   logic                 wready;
   logic [ADDR_SIZE-1:0] waddr;
   burst_size_t          wburst_size;
   logic [DATA_SIZE-1:0] wdata;
   logic                 pool_wen;
   logic                 pool_wready;
   logic [ADDR_SIZE-1:0] pool_waddr;
   logic [DATA_SIZE-1:0] pool_wdata;
   logic [7:0]           pool_wstrb;
   logic                 misalign_err;
   logic [2:0]           fifo_count;

   always #5 clk = ~clk;

   write_data_aligner #(
      .ADDR_SIZE (ADDR_SIZE),
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (DEPTH)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .wvalid       (wvalid),
      .wready       (wready),
      .waddr        (waddr),
      .wburst_size  (wburst_size),
      .wdata        (wdata),
      .pool_wen     (pool_wen),
      .pool_wready  (pool_wready),
      .pool_waddr   (pool_waddr),
      .pool_wdata   (pool_wdata),
      .pool_wstrb   (pool_wstrb),
      .misalign_err (misalign_err),
      .fifo_count   (fifo_count)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [63:0] data;
      logic [7:0]  strb;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] s);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.strb = s;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (n_rst && pool_wen && pool_wready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL pool_write_unexpected: got addr %h data %h strb %h, none expected",
                     pool_waddr, pool_wdata, pool_wstrb);
         end else begin
            mon_e = sb.pop_front();
            check("pool_waddr", 64'(pool_waddr), 64'(mon_e.addr));
            check("pool_wdata", pool_wdata, mon_e.data);
            check("pool_wstrb", 64'(pool_wstrb), 64'(mon_e.strb));
         end
      end
   end

   task automatic cycles(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns one time unit after the edge on which the beat was accepted.
   task automatic send_beat(input logic [7:0] a, input burst_size_t s, input logic [63:0] d);
      bit ok = 1'b0;
      wvalid      = 1'b1;
      waddr       = a;
      wburst_size = s;
      wdata       = d;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (wready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_mis++;
         $display("FAIL send_timeout: wready stayed 0 for addr %h, required 1", a);
      end
      @(posedge clk);
      #1;
      wvalid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required self-termination");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  a;
      logic [63:0] d;

      n_rst       = 1'b0;
      wvalid      = 1'b0;
      waddr       = '0;
      wburst_size = ONE_BYTE;
      wdata       = '0;
      pool_wready = 1'b0;
      #12;
      check("rst_wready", 64'(wready), 64'd1);
      check("rst_pool_wen", 64'(pool_wen), 64'd0);
      check("rst_fifo_count", 64'(fifo_count), 64'd0);
      check("rst_misalign_err", 64'(misalign_err), 64'd0);
      check("rst_pool_waddr", 64'(pool_waddr), 64'd0);
      check("rst_pool_wdata", pool_wdata, 64'd0);
      check("rst_pool_wstrb", 64'(pool_wstrb), 64'd0);
      @(negedge clk);
      n_rst = 1'b1;
      cycles(1);

      // Four bytes at column 4, upper input bytes are junk and must be ignored.
      pool_wready = 1'b1;
      expect_write(8'h10, 64'hDEADBEEF_00000000, 8'hF0);
      send_beat(8'h14, FOUR_BYTES, 64'hCAFEF00D_DEADBEEF);
      check("lat_n1_pool_wen", 64'(pool_wen), 64'd0);
      cycles(1);
      check("lat_n2_pool_wen", 64'(pool_wen), 64'd1);
      cycles(2);
      check("t1_drained", 64'(fifo_count), 64'd0);

      // Two beats to the same word coalesce into one entry.
      pool_wready = 1'b0;
      send_beat(8'h20, ONE_BYTE, 64'h11223344_556677AA);
      send_beat(8'h22, TWO_BYTES, 64'hFFFFFFFF_FFFF1234);
      cycles(1);
      check("merge_count", 64'(fifo_count), 64'd1);
      check("merge_waddr", 64'(pool_waddr), 64'h20);
      check("merge_wdata", pool_wdata, 64'h00000000_123400AA);
      check("merge_wstrb", 64'(pool_wstrb), 64'h0D);
      expect_write(8'h20, 64'h00000000_123400AA, 8'h0D);
      pool_wready = 1'b1;
      cycles(2);
      check("t2_drained", 64'(fifo_count), 64'd0);

      // Misaligned beat is accepted, dropped, and flagged for one cycle.
      send_beat(8'h07, TWO_BYTES, 64'h5555);
      check("mis_err_pulse", 64'(misalign_err), 64'd1);
      check("mis_count", 64'(fifo_count), 64'd0);
      check("mis_wready", 64'(wready), 64'd1);
      cycles(1);
      check("mis_err_clear", 64'(misalign_err), 64'd0);
      check("mis_no_wen", 64'(pool_wen), 64'd0);
      send_beat(8'h39, EIGHT_BYTES, 64'h0123456789ABCDEF);
      check("mis8_err_pulse", 64'(misalign_err), 64'd1);
      cycles(2);
      check("mis8_no_wen", 64'(pool_wen), 64'd0);

      // Single byte at column 7 is the aligned edge case.
      expect_write(8'h00, 64'hAA000000_00000000, 8'h80);
      send_beat(8'h07, ONE_BYTE, 64'hFFFFFFFF_FFFFFFAA);
      check("col7_no_err", 64'(misalign_err), 64'd0);
      cycles(3);
      check("col7_drained", 64'(fifo_count), 64'd0);

      // Fill FIFO plus align register, then pop, push and accept on the same edge.
      pool_wready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a = 8'h40 + 8'(8 * i);
         d = {32'hA5A50000 + 32'(i), 32'h0F0F0000 + 32'(i)};
         expect_write(a, d, 8'hFF);
         send_beat(a, EIGHT_BYTES, d);
      end
      check("full_count", 64'(fifo_count), 64'd4);
      check("full_wready", 64'(wready), 64'd0);
      check("full_head", 64'(pool_waddr), 64'h40);
      cycles(1);
      check("full_hold_count", 64'(fifo_count), 64'd4);
      check("full_hold_wready", 64'(wready), 64'd0);
      expect_write(8'hA0, 64'h13572468_9BDF0ACE, 8'hFF);
      pool_wready = 1'b1;
      send_beat(8'hA0, EIGHT_BYTES, 64'h13572468_9BDF0ACE);
      check("full_pushpop_count", 64'(fifo_count), 64'd4);
      check("full_pushpop_head", 64'(pool_waddr), 64'h48);
      cycles(5);
      check("drain_rate_count", 64'(fifo_count), 64'd0);
      check("drain_sb_empty", 64'(sb.size()), 64'd0);

      // Reset with three entries pending discards them.
      pool_wready = 1'b0;
      send_beat(8'hC0, EIGHT_BYTES, 64'h1111111111111111);
      send_beat(8'hC8, EIGHT_BYTES, 64'h2222222222222222);
      send_beat(8'hD0, EIGHT_BYTES, 64'h3333333333333333);
      cycles(1);
      check("prerst_count", 64'(fifo_count), 64'd3);
      #2;
      n_rst = 1'b0;
      #1;
      check("midrst_pool_wen", 64'(pool_wen), 64'd0);
      check("midrst_count", 64'(fifo_count), 64'd0);
      check("midrst_wready", 64'(wready), 64'd1);
      check("midrst_wdata", pool_wdata, 64'd0);
      @(negedge clk);
      n_rst = 1'b1;
      pool_wready = 1'b1;
      cycles(4);
      check("postrst_pool_wen", 64'(pool_wen), 64'd0);
      check("postrst_count", 64'(fifo_count), 64'd0);
      expect_write(8'hE8, 64'hBEEF0000_00000000, 8'hC0);
      send_beat(8'hEE, TWO_BYTES, 64'h0000BEEF);
      cycles(3);
      check("postrst_drained", 64'(fifo_count), 64'd0);

      cycles(2);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
